// File: rtl/ifetch_packet_fifo_if.sv
// Fetch-to-decode packet FIFO bus.
// Optional stall counter port is present only when IFETCH_FIFO_STATS_EN is defined.
//
// Handshake: a packet moves in on a rising edge when iFetchVld=1, oFetchFull=0
// and iFlush=0. The head packet moves out on a rising edge when iReadFifo=1,
// oRcvFifoEmpty=0 and iFlush=0. A rejected write must be held and retried. All
// o* signals come from registered state only.
interface ifetch_packet_fifo_if #(
  parameter int IW    = 32,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic            iFlush;
  logic            iFetchVld;
  logic [4*IW-1:0] iFetchInstrs;
  logic            oFetchFull;
  logic            oAlmostFull;
  logic            iReadFifo;
  logic [4*IW-1:0] oRcvInstrs;
  logic            oRcvFifoEmpty;
  logic [AW:0]     oCount;
`ifdef IFETCH_FIFO_STATS_EN
  logic [15:0]     oStallCnt;
`endif

  // Fetch/decode side
  modport master (
    output iFlush, iFetchVld, iFetchInstrs, iReadFifo,
`ifdef IFETCH_FIFO_STATS_EN
    input  oStallCnt,
`endif
    input  oFetchFull, oAlmostFull, oRcvInstrs, oRcvFifoEmpty, oCount
  );

  // FIFO side
  modport slave (
    input  iFlush, iFetchVld, iFetchInstrs, iReadFifo,
`ifdef IFETCH_FIFO_STATS_EN
    output oStallCnt,
`endif
    output oFetchFull, oAlmostFull, oRcvInstrs, oRcvFifoEmpty, oCount
  );
endinterface

// File: rtl/ifetch_packet_fifo.sv
// First-word-fall-through FIFO of 4-instruction fetch packets with flush.
// Optional feature macro: IFETCH_FIFO_STATS_EN adds a saturating 16-bit count
// of cycles where fetch presented a packet while the FIFO was full.
module ifetch_packet_fifo #(
  parameter int IW        = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_THR = DEPTH - 2
) (
  input  logic                 iClk,
  input  logic                 iResetn,
  ifetch_packet_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THR);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [4*IW-1:0] mem_q [DEPTH];

  logic        empty;
  logic        full;
  logic        wr_en;
  logic        rd_en;
  logic [AW:0] count;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  // Full is judged on the registered state, so a same-cycle pop never frees a slot
  assign wr_en = bus.iFetchVld & ~full  & ~bus.iFlush;
  assign rd_en = bus.iReadFifo & ~empty & ~bus.iFlush;

  // Next pointers: flush collapses the read pointer onto the write pointer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.iFlush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Packet storage; contents are meaningless until written, so no reset
  always_ff @(posedge iClk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.iFetchInstrs;
  end

  assign bus.oRcvFifoEmpty = empty;
  assign bus.oFetchFull    = full;
  assign bus.oAlmostFull   = (count >= AFULL_LVL);
  assign bus.oCount        = count;
  assign bus.oRcvInstrs    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

`ifdef IFETCH_FIFO_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of back-pressured fetch cycles; only reset clears it
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      stall_cnt_q <= '0;
    end else if (bus.iFetchVld && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.oStallCnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_packet_fifo.sv
// Self-checking bench for ifetch_packet_fifo (IW=32, DEPTH=4) against a
// queue-based reference model.
module tb_ifetch_packet_fifo;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 4 * IW;

  logic iClk;
  logic iResetn;

  ifetch_packet_fifo_if #(.IW(IW), .DEPTH(DEPTH)) bus ();

  ifetch_packet_fifo #(.IW(IW), .DEPTH(DEPTH)) dut (
    .iClk    (iClk),
    .iResetn (iResetn),
    .bus     (bus)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Scoreboard: expected FIFO contents, oldest first
  logic [PW-1:0] exp_q[$];
  int unsigned   stall_exp;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's current contents
  task automatic check_outputs(input string tag);
    logic [PW-1:0] head;
    int sz;
    sz   = exp_q.size();
    head = (sz == 0) ? '0 : exp_q[0];
    check({tag, ".empty"}, PW'(bus.oRcvFifoEmpty), PW'(sz == 0));
    check({tag, ".full"},  PW'(bus.oFetchFull),    PW'(sz == DEPTH));
    check({tag, ".afull"}, PW'(bus.oAlmostFull),   PW'(sz >= DEPTH - 2));
    check({tag, ".count"}, PW'(bus.oCount),        PW'(sz));
    check({tag, ".head"},  bus.oRcvInstrs,         head);
`ifdef IFETCH_FIFO_STATS_EN
    check({tag, ".stall"}, PW'(bus.oStallCnt),     PW'(stall_exp));
`endif
  endtask

  // One clock cycle: drive at negedge, check, take the edge, update model
  task automatic step(input string tag, input logic f, input logic v,
                      input logic [PW-1:0] d, input logic r);
    int sz;
    bus.iFlush       = f;
    bus.iFetchVld    = v;
    bus.iFetchInstrs = d;
    bus.iReadFifo    = r;
    #1;
    check_outputs(tag);
    sz = exp_q.size();
    @(posedge iClk);
    if (v && sz == DEPTH && stall_exp < 32'hFFFF) stall_exp++;
    if (f) begin
      exp_q.delete();
    end else begin
      if (r && sz > 0) void'(exp_q.pop_front());
      if (v && sz < DEPTH) exp_q.push_back(d);
    end
    @(negedge iClk);
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [PW-1:0] fill_pkt(input int i);
    logic [PW-1:0] p;
    p = rand_pkt();
    p[IW-1:0] = 32'h0000_0013 + i;
    return p;
  endfunction

  initial begin
    logic [PW-1:0] pkt;
    n_tests   = 0;
    n_fail    = 0;
    stall_exp = 0;
    iResetn          = 1'b0;
    bus.iFlush       = 1'b0;
    bus.iFetchVld    = 1'b0;
    bus.iFetchInstrs = '0;
    bus.iReadFifo    = 1'b0;
    repeat (2) @(negedge iClk);
    iResetn = 1'b1;

    // Reset state
    step("reset", 0, 0, '0, 0);

    // Async reset mid-stream after three writes, no clock edge needed
    for (int i = 0; i < 3; i++) step("pre_rst", 0, 1, fill_pkt(i), 0);
    #2;
    iResetn = 1'b0;
    #1;
    check("arst.empty", PW'(bus.oRcvFifoEmpty), PW'(1));
    check("arst.count", PW'(bus.oCount), PW'(0));
    check("arst.head",  bus.oRcvInstrs, '0);
    check("arst.full",  PW'(bus.oFetchFull), PW'(0));
    exp_q.delete();
    stall_exp = 0;
    @(negedge iClk);
    iResetn = 1'b1;
    step("post_rst", 0, 0, '0, 0);

    // Fill P0..P3, then a rejected fifth write
    for (int i = 0; i < 5; i++) step("fill", 0, 1, fill_pkt(i), 0);
    check("fill.count4", PW'(bus.oCount), PW'(4));

    // Drain in order, then a pop on empty
    for (int i = 0; i < 5; i++) step("drain", 0, 0, '0, 1);
    check("drain.count0", PW'(bus.oCount), PW'(0));

    // Concurrent read/write at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) step("pre_rw", 0, 1, rand_pkt(), 0);
    for (int i = 0; i < 10; i++) step("rw", 0, 1, rand_pkt(), 1);
    check("rw.count2", PW'(bus.oCount), PW'(2));

    // Flush with concurrent write and read at occupancy 3
    step("pre_fl", 0, 1, rand_pkt(), 0);
    step("flush", 1, 1, rand_pkt(), 1);
    check("flush.empty", PW'(bus.oRcvFifoEmpty), PW'(1));
    pkt = {4{32'hDEADBEEF}};
    step("post_fl", 0, 1, pkt, 0);
    check("post_fl.head", bus.oRcvInstrs, pkt);
    step("post_fl2", 0, 0, '0, 1);

    // Back-pressure: hold a packet while full
    for (int i = 0; i < 4; i++) step("stall_fill", 0, 1, rand_pkt(), 0);
    for (int i = 0; i < 5; i++) step("stall", 0, 1, rand_pkt(), 0);
    step("stall_end", 0, 0, '0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
           rand_pkt(), ($urandom_range(0, 2) != 0));
    end
    step("final", 0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifetch_packet_fifo.md
Name: ifetch_packet_fifo

Overview:
- Buffers 4-instruction fetch packets between the fetch unit and the instruction decoder.
- Write side: the fetch unit pushes one packet per accepted cycle.
- Read side: first-word-fall-through. The decoder samples the head packet and the empty flag, and pops by asserting its read strobe.
- Supports pipeline flush after redirect/branch mispredict.

Parameters:
- IW, 32, instruction width in bits; packet width is 4*IW.
- DEPTH, 8, number of packet entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer index width; derived, not overridden.
- AFULL_THR, DEPTH-2, occupancy at or above which oAlmostFull asserts.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iResetn  input  1  asynchronous active-low reset.
- iFlush  input  1  synchronous flush; empties the FIFO.
- iFetchVld  input  1  fetch unit presents a packet this cycle.
- iFetchInstrs  input  4*IW  packet; instr0 in [IW-1:0], instr3 in [4*IW-1:3*IW].
- oFetchFull  output  1  FIFO full; a write in this cycle is rejected.
- oAlmostFull  output  1  occupancy >= AFULL_THR; lookahead stall for fetch.
- iReadFifo  input  1  decoder pops the head packet.
- oRcvInstrs  output  4*IW  head packet; all zeros when empty.
- oRcvFifoEmpty  output  1  no valid packet at head.
- oCount  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
Reset:
- Async assert of iResetn clears wr_ptr and rd_ptr (AW+1 bits each, MSB is the wrap bit).
- Reset outputs: oRcvFifoEmpty=1, oFetchFull=0, oAlmostFull=0, oCount=0, oRcvInstrs=0.
- Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately.

Status flags:
- Empty when wr_ptr==rd_ptr.
- Full when index bits are equal and wrap bits differ.
- oCount = wr_ptr - rd_ptr, modulo 2^(AW+1).
- All flags are derived only from registered pointers. There is no combinational path from iFetchVld or iReadFifo to any output.

Write:
- Accepted when iFetchVld & ~oFetchFull & ~iFlush.
- Packet is stored at mem[wr_ptr[AW-1:0]]; wr_ptr increments.
- Rejected write: no state change. The fetch unit must hold the packet and retry.
- Write while full is rejected even if a read occurs in the same cycle.

Read:
- Accepted when iReadFifo & ~oRcvFifoEmpty & ~iFlush; rd_ptr increments.
- Read while empty is ignored, with no pointer underflow.
- oRcvInstrs = mem[rd_ptr[AW-1:0]] when not empty, else 0.

Latency:
- A packet written in cycle N is visible at the head (empty deasserted) in cycle N+1.
- A pop in cycle N exposes the next packet in cycle N+1.

Simultaneous events:
- Accepted read and write in the same cycle: both pointers advance and occupancy is unchanged.
- Non-full, non-empty case: both operations are accepted.
- Empty: the write is accepted and the read is ignored.

Flush:
- iFlush=1 in cycle N sets rd_ptr to wr_ptr at the edge ending cycle N.
- In cycle N+1: oRcvFifoEmpty=1 and oCount=0.
- Any write or read in cycle N is discarded.
- Flush takes priority over all other operations.

Wrap-around:
- Pointers roll modulo 2^(AW+1).
- No behavioural discontinuity occurs at the DEPTH boundary.

Optional Feature:
IFETCH_FIFO_STATS_EN
- Defined:
  - Adds output oStallCnt [15:0].
  - The counter increments each cycle iFetchVld & oFetchFull, and saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
- Config: IW=32, DEPTH=4 unless noted.
- Reset check: assert iResetn=0 mid-stream after 3 writes -> oRcvFifoEmpty=1, oCount=0, oRcvInstrs=0, oFetchFull=0 with no clock edge required.
- Fill: write packets P0..P3 with instr0=32'h00000013+i, no reads -> oCount 1,2,3,4; oAlmostFull from oCount=2; oFetchFull=1 after 4th. 5th write P4 is rejected; oCount stays 4.
- Drain and order: pop 4 times from full -> oRcvInstrs sequence P0,P1,P2,P3, then 0 with oRcvFifoEmpty=1. A 5th pop leaves oCount=0.
- Concurrent read/write at oCount=2 for 10 cycles across pointer wrap -> oCount holds 2; output order matches write order exactly.
- Flush with concurrent write and read at oCount=3 -> next cycle oCount=0, empty=1. A following write of 32'hDEADBEEF packet appears at head one cycle later.
- STATS_EN build: hold iFetchVld=1 while full for 5 cycles -> oStallCnt=5. Preload near 16'hFFFF -> saturates, no wrap.
